// File: rtl/plank_fdbk_parser.sv
// PLANK reply-frame parser: reassembles feedback, ADC and temperature frames from a UART byte
// stream, with frame-format checks and an inter-byte timeout.
module plank_fdbk_parser #(
    parameter int unsigned TIMEOUT_CLKS = 34720,
    parameter logic [7:0]  FB_SYNC0     = 8'hEE,
    parameter logic [7:0]  FB_SYNC1     = 8'hBB
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_valid,
    output logic        o_fb_tx_rx_sel,
    output logic [7:0]  o_fb_ch_power,
    output logic        o_fb_valid,
    output logic [95:0] o_adc_data,
    output logic        o_adc_valid,
    output logic [24:0] o_temp_data,
    output logic        o_temp_valid,
    output logic        o_frame_err,
    output logic [1:0]  o_err_code
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CLKS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFbS1   = 3'd1;
    localparam logic [2:0] StFbBody = 3'd2;
    localparam logic [2:0] StAdc    = 3'd3;
    localparam logic [2:0] StTemp   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // Only 11 ADC bytes need buffering; the 12th goes straight to the output word.
    logic [87:0]   adc_buf_q, adc_buf_d;
    logic [23:0]   temp_buf_q, temp_buf_d;
    logic [7:0]    ch_pwr_q, ch_pwr_d;
    logic          sel_q, sel_d;
    logic [7:0]    pwr_q, pwr_d;
    logic [95:0]   adc_data_q, adc_data_d;
    logic [24:0]   temp_data_q, temp_data_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          fb_valid_q, fb_valid_d;
    logic          adc_valid_q, adc_valid_d;
    logic          temp_valid_q, temp_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          tmo_hit;
    logic [87:0]   adc_shift;

    // A byte in the same cycle as expiry clears the counter, so it suppresses the timeout.
    assign tmo_hit   = !i_rx_valid && (state_q != StIdle) && (tmo_q >= TMO_HIT);
    assign adc_shift = {i_rx_byte, adc_buf_q[87:8]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        adc_buf_d    = adc_buf_q;
        temp_buf_d   = temp_buf_q;
        ch_pwr_d     = ch_pwr_q;
        sel_d        = sel_q;
        pwr_d        = pwr_q;
        adc_data_d   = adc_data_q;
        temp_data_d  = temp_data_q;
        err_code_d   = err_code_q;
        fb_valid_d   = 1'b0;
        adc_valid_d  = 1'b0;
        temp_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (i_rx_valid || state_q == StIdle) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end

        if (i_rx_valid) begin
            case (state_q)
                StIdle: begin
                    // Buffered speculatively: a failed sync turns it into ADC byte0.
                    adc_buf_d = adc_shift;
                    cnt_d     = 4'd1;
                    state_d   = (i_rx_byte == FB_SYNC0) ? StFbS1 : StAdc;
                end
                StFbS1: begin
                    adc_buf_d = adc_shift;
                    cnt_d     = 4'd2;
                    state_d   = (i_rx_byte == FB_SYNC1) ? StFbBody : StAdc;
                end
                StFbBody: begin
                    if (cnt_q == 4'd2) begin
                        ch_pwr_d = i_rx_byte;
                        cnt_d    = 4'd3;
                    end else begin
                        if (i_rx_byte[7:1] == 7'd0) begin
                            sel_d      = i_rx_byte[0];
                            pwr_d      = ch_pwr_q;
                            fb_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'b10;
                        end
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end
                end
                StAdc: begin
                    if (cnt_q == 4'd11) begin
                        adc_data_d  = {i_rx_byte, adc_buf_q};
                        adc_valid_d = 1'b1;
                        cnt_d       = 4'd0;
                        state_d     = StTemp;
                    end else begin
                        adc_buf_d = adc_shift;
                        cnt_d     = cnt_q + 4'd1;
                    end
                end
                StTemp: begin
                    if (cnt_q == 4'd3) begin
                        if (i_rx_byte[7:1] == 7'd0) begin
                            temp_data_d  = {i_rx_byte[0], temp_buf_q};
                            temp_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'b10;
                        end
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end else begin
                        temp_buf_d = {i_rx_byte, temp_buf_q[23:8]};
                        cnt_d      = cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end
            endcase
        end else if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            cnt_d       = 4'd0;
            state_d     = StIdle;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tmo_q        <= '0;
            adc_buf_q    <= '0;
            temp_buf_q   <= '0;
            ch_pwr_q     <= '0;
            sel_q        <= 1'b0;
            pwr_q        <= '0;
            adc_data_q   <= '0;
            temp_data_q  <= '0;
            err_code_q   <= '0;
            fb_valid_q   <= 1'b0;
            adc_valid_q  <= 1'b0;
            temp_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            adc_buf_q    <= adc_buf_d;
            temp_buf_q   <= temp_buf_d;
            ch_pwr_q     <= ch_pwr_d;
            sel_q        <= sel_d;
            pwr_q        <= pwr_d;
            adc_data_q   <= adc_data_d;
            temp_data_q  <= temp_data_d;
            err_code_q   <= err_code_d;
            fb_valid_q   <= fb_valid_d;
            adc_valid_q  <= adc_valid_d;
            temp_valid_q <= temp_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_fb_tx_rx_sel = sel_q;
    assign o_fb_ch_power  = pwr_q;
    assign o_fb_valid     = fb_valid_q;
    assign o_adc_data     = adc_data_q;
    assign o_adc_valid    = adc_valid_q;
    assign o_temp_data    = temp_data_q;
    assign o_temp_valid   = temp_valid_q;
    assign o_frame_err    = frame_err_q;
    assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_plank_fdbk_parser.sv
// Bench for plank_fdbk_parser: directed frame table, timeout/reset sequences, and a random byte
// stream checked every cycle against a queue-based frame model.
module tb_plank_fdbk_parser;

    localparam int unsigned TMO = 40;
    localparam int KFB = 1, KADC = 2, KTEMP = 3, KERR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        fb_sel, fb_valid, adc_valid, temp_valid, frame_err;
    logic [7:0]  fb_pwr;
    logic [95:0] adc_data;
    logic [24:0] temp_data;
    logic [1:0]  err_code;

    plank_fdbk_parser #(.TIMEOUT_CLKS(TMO), .FB_SYNC0(8'hEE), .FB_SYNC1(8'hBB)) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_rx_byte     (rx_byte),
        .i_rx_valid    (rx_valid),
        .o_fb_tx_rx_sel(fb_sel),
        .o_fb_ch_power (fb_pwr),
        .o_fb_valid    (fb_valid),
        .o_adc_data    (adc_data),
        .o_adc_valid   (adc_valid),
        .o_temp_data   (temp_data),
        .o_temp_valid  (temp_valid),
        .o_frame_err   (frame_err),
        .o_err_code    (err_code)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the partial frame is a byte queue; frame type is read off its contents.
    logic [7:0]  mq[$];
    bit          m_temp;
    int          m_idle;
    logic        e_sel, e_fbv, e_adcv, e_tempv, e_err;
    logic [7:0]  e_pwr;
    logic [95:0] e_adc;
    logic [24:0] e_temp;
    logic [1:0]  e_code;

    task automatic model_reset();
        mq.delete();
        m_temp = 0; m_idle = 0;
        e_sel = 0; e_fbv = 0; e_adcv = 0; e_tempv = 0; e_err = 0;
        e_pwr = '0; e_adc = '0; e_temp = '0; e_code = '0;
    endtask

    task automatic model_err(input logic [1:0] code);
        e_err = 1'b1;
        e_code = code;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic [7:0] lb;
        e_fbv = 0; e_adcv = 0; e_tempv = 0; e_err = 0;
        if (v) begin
            m_idle = 0;
            mq.push_back(b);
            lb = b;
            if (m_temp) begin
                if (mq.size() == 4) begin
                    if (lb[7:1] == 7'd0) begin
                        e_temp = {lb[0], mq[2], mq[1], mq[0]};
                        e_tempv = 1'b1;
                    end else model_err(2'b10);
                    mq.delete();
                    m_temp = 0;
                end
            end else if (mq[0] == 8'hEE && (mq.size() == 1 || mq[1] == 8'hBB)) begin
                if (mq.size() == 4) begin
                    if (lb[7:1] == 7'd0) begin
                        e_sel = lb[0];
                        e_pwr = mq[2];
                        e_fbv = 1'b1;
                    end else model_err(2'b10);
                    mq.delete();
                end
            end else if (mq.size() == 12) begin
                for (int k = 0; k < 12; k++) e_adc[8*k +: 8] = mq[k];
                e_adcv = 1'b1;
                mq.delete();
                m_temp = 1;
            end
        end else if (mq.size() != 0 || m_temp) begin
            m_idle++;
            if (m_idle == int'(TMO)) begin
                model_err(2'b01);
                mq.delete();
                m_temp = 0;
                m_idle = 0;
            end
        end
    endtask

    task automatic check_model(input string name);
        n_total++;
        if (fb_valid !== e_fbv || adc_valid !== e_adcv || temp_valid !== e_tempv ||
            frame_err !== e_err || err_code !== e_code || fb_sel !== e_sel ||
            fb_pwr !== e_pwr || adc_data !== e_adc || temp_data !== e_temp) begin
            $display("FAIL %s t=%0t got v=%b%b%b%b code=%b sel=%b pwr=%h adc=%h temp=%h exp v=%b%b%b%b code=%b sel=%b pwr=%h adc=%h temp=%h",
                     name, $time, fb_valid, adc_valid, temp_valid, frame_err, err_code, fb_sel,
                     fb_pwr, adc_data, temp_data, e_fbv, e_adcv, e_tempv, e_err, e_code, e_sel,
                     e_pwr, e_adc, e_temp);
        end else n_pass++;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got %b expected %b", name, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte = b;
        @(posedge clk);
        model_step(v, b);
        #1;
        check_model("model");
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    // Bytes listed in wire order, first byte in the most significant position.
    task automatic send_seq(input int n, input logic [127:0] seq, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 3));
            tick(1'b1, seq[8*(n-1-i) +: 8]);
        end
    endtask

    typedef struct {
        int           n;
        logic [127:0] seq;
        int           kind;
        logic [95:0]  data;
        logic [1:0]   code;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int n, input logic [127:0] seq, input int kind,
                           input logic [95:0] data, input logic [1:0] code);
        vec_t v;
        v.n = n; v.seq = seq; v.kind = kind; v.data = data; v.code = code;
        vecs.push_back(v);
    endtask

    initial begin
        logic ok;
        int   gap, r;
        logic [7:0] b;

        add_vec(4, 128'hEEBB5A01, KFB, 96'h15A, 2'b00);
        add_vec(12, 128'hCCAAABEFBEADDEEFBEADDEAC, KADC, 96'hACDEADBEEFDEADBEEFABAACC, 2'b00);
        add_vec(4, 128'hDD202000, KTEMP, 96'h02020DD, 2'b00);
        add_vec(4, 128'hEEBB5A07, KERR, 96'h0, 2'b10);
        add_vec(4, 128'hEEBB3300, KFB, 96'h033, 2'b00);
        add_vec(12, 128'hEE120102030405060708090A, KADC, 96'h0A090807060504030201_12EE, 2'b00);
        add_vec(4, 128'h01020302, KERR, 96'h0, 2'b10);
        add_vec(4, 128'hEEBB5A01, KFB, 96'h15A, 2'b00);

        model_reset();
        #12;
        check_model("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) begin
            send_seq(vecs[i].n, vecs[i].seq, 1'b1);
            case (vecs[i].kind)
                KFB:   ok = fb_valid && !frame_err && fb_sel == vecs[i].data[8] &&
                            fb_pwr == vecs[i].data[7:0];
                KADC:  ok = adc_valid && !frame_err && adc_data == vecs[i].data;
                KTEMP: ok = temp_valid && !frame_err && temp_data == vecs[i].data[24:0];
                default: ok = frame_err && err_code == vecs[i].code && !fb_valid && !temp_valid;
            endcase
            n_total++;
            if (!ok) $display("FAIL vec%0d kind=%0d got fbv=%b adcv=%b tv=%b err=%b code=%b sel=%b pwr=%h adc=%h temp=%h required data=%h code=%b",
                              i, vecs[i].kind, fb_valid, adc_valid, temp_valid, frame_err,
                              err_code, fb_sel, fb_pwr, adc_data, temp_data, vecs[i].data,
                              vecs[i].code);
            else n_pass++;
            idle($urandom_range(0, 3));
        end

        // Timeout after sync: silent for one cycle less than the limit, then expire.
        send_seq(2, 128'hEEBB, 1'b0);
        idle(TMO - 1);
        check_bit("tmo_early", frame_err, 1'b0);
        idle(1);
        check_bit("tmo_err", frame_err, 1'b1);
        check_bit("tmo_code", err_code == 2'b01, 1'b1);
        send_seq(4, 128'hEEBB4401, 1'b1);
        check_bit("fb_after_tmo", fb_valid, 1'b1);

        // Byte lands on the expiry cycle and must win.
        send_seq(2, 128'hEEBB, 1'b0);
        idle(TMO - 1);
        tick(1'b1, 8'h5A);
        check_bit("expiry_byte_no_err", frame_err, 1'b0);
        tick(1'b1, 8'h01);
        check_bit("expiry_fb_valid", fb_valid, 1'b1);
        idle(2);

        // Reset mid-ADC-frame.
        send_seq(6, 128'h111213141516, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model("reset_mid_frame");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_seq(4, 128'hEEBB5A01, 1'b1);
        check_bit("post_reset_fb", fb_valid && fb_pwr == 8'h5A && fb_sel, 1'b1);
        check_bit("post_reset_adc_clear", adc_data == 96'h0, 1'b1);

        // Random stream, biased toward sync/flag bytes, with occasional stalls past the limit.
        for (int i = 0; i < 600; i++) begin
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 2, TMO + 3)
                                               : $urandom_range(0, 2);
            idle(gap);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: b = 8'hEE;
                2:    b = 8'hBB;
                3:    b = 8'h00;
                4:    b = 8'h01;
                default: b = 8'($urandom);
            endcase
            tick(1'b1, b);
        end
        idle(TMO + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
